// File: rtl/acorn128_host_if_pkg.sv
// acorn128_host_if_pkg
// Shared definitions for the ACORN-128 host interface slice:
//   state_t   - controller states (LOAD, RUN, DRAIN, CLR)
//   WORD_W    - host bus word width
//   WORDS_IN  - host beats per load (key, IV, AD, PT x 4 words)
//   WORDS_OUT - output words per result (ct x 4, tag x 4)
//   DATA_LEN  - fixed message length reported to the core
package acorn128_host_if_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        CLR   = 2'd3
    } state_t;

    localparam int WORD_W    = 32;
    localparam int WORDS_IN  = 16;
    localparam int WORDS_OUT = 8;
    localparam int DATA_LEN  = 128;

endpackage

// File: rtl/acorn128_host_if_if.sv
// acorn128_host_if_if
// Host-side streaming bus of the ACORN-128 host interface.
//   s_valid/s_ready/s_data : host -> block input words
//   m_valid/m_ready/m_data : block -> host output words
//   m_last                 : marks the final output word
// Modports:
//   master - the host side (drives s_valid, s_data, m_ready)
//   slave  - the acorn128_host_if block
interface acorn128_host_if_if;
    import acorn128_host_if_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [WORD_W-1:0] m_data;
    logic              m_last;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

endinterface

// File: rtl/acorn128_host_if_word_pack.sv
// acorn128_word_pack
// Assembles one 128-bit field from four 32-bit host words. Each load shifts
// the new word in at the top, so after four loads word k sits at bits
// [32k+31:32k] (first word ends up least significant).
// Ports:
//   clk, rst - clock and asynchronous active-high reset
//   load     - shift in 'word' this cycle
//   word     - incoming 32-bit host word
//   field    - assembled 128-bit field
module acorn128_word_pack
    import acorn128_host_if_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WORD_W-1:0]     word,
    output logic [4*WORD_W-1:0]   field
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            field <= '0;
        end else if (load) begin
            field <= {word, field[4*WORD_W-1:WORD_W]};
        end
    end

endmodule

// File: rtl/acorn128_host_if.sv
// acorn128_host_if
// Host adapter for an ACORN-128 cipher core. Collects 16 host words
// (key, IV, AD, PT - four words each, low word first), starts the core,
// waits for it, then streams ciphertext and tag (8 words, low word first)
// back to the host, pulses core_rst and returns to loading.
// Ports:
//   clk, rst        - clock and asynchronous active-high reset
//   bus (slave)     - host input/output stream (see acorn128_host_if_if)
//   core_rst        - one-cycle reset pulse to the core after each result
//   core_start      - held high while the core is running
//   core_encrypt    - encrypt select (mirrors core_start)
//   core_key/iv/ad/pt, core_len - operands to the core
//   core_ready      - core done; core_ct/core_tag valid
//   busy            - high in RUN or DRAIN
//   timeout_err     - sticky abort flag
// Configuration:
//   ACORN128_HOST_TIMEOUT_EN - when defined, RUN aborts after TIMEOUT_CYCLES
//   cycles without core_ready; otherwise RUN waits forever and timeout_err=0.
module acorn128_host_if
    import acorn128_host_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8191
)
(
    input  logic                 clk,
    input  logic                 rst,
    acorn128_host_if_if.slave    bus,
    output logic                 core_rst,
    output logic                 core_start,
    output logic                 core_encrypt,
    output logic [127:0]         core_key,
    output logic [127:0]         core_iv,
    output logic [127:0]         core_ad,
    output logic [127:0]         core_pt,
    output logic [63:0]          core_len,
    input  logic                 core_ready,
    input  logic [127:0]         core_ct,
    input  logic [127:0]         core_tag,
    output logic                 busy,
    output logic                 timeout_err
);

    // The run counter is 13 bits wide, so larger limits cannot be honoured.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 8191) begin : g_bad_timeout
        $error("acorn128_host_if: TIMEOUT_CYCLES out of range 1..8191");
    end

    state_t         state;
    logic [3:0]     word_cnt;
    logic [2:0]     out_cnt;
    logic [255:0]   out_buf;
    logic           s_ready_q;
    logic           m_valid_q;
    logic           beat;
    logic [127:0]   field_q [4];

`ifdef ACORN128_HOST_TIMEOUT_EN
    logic [12:0]    run_cnt;
    logic           timeout_q;
`endif

    assign beat = (state == LOAD) && bus.s_valid && s_ready_q;

    // word_cnt[3:2] selects the field (key, IV, AD, PT) taking this beat.
    for (genvar f = 0; f < 4; f++) begin : g_pack
        acorn128_word_pack u_pack (
            .clk   (clk),
            .rst   (rst),
            .load  (beat && (word_cnt[3:2] == 2'(f))),
            .word  (bus.s_data),
            .field (field_q[f])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD;
            word_cnt   <= '0;
            out_cnt    <= '0;
            out_buf    <= '0;
            s_ready_q  <= 1'b1;
            m_valid_q  <= 1'b0;
            core_start <= 1'b0;
            core_rst   <= 1'b0;
`ifdef ACORN128_HOST_TIMEOUT_EN
            run_cnt    <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    if (beat) begin
                        word_cnt <= word_cnt + 4'd1;
`ifdef ACORN128_HOST_TIMEOUT_EN
                        timeout_q <= 1'b0;
                        run_cnt   <= '0;
`endif
                        if (word_cnt == 4'(WORDS_IN - 1)) begin
                            state      <= RUN;
                            s_ready_q  <= 1'b0;
                            core_start <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (core_ready) begin
                        out_buf    <= {core_tag, core_ct};
                        out_cnt    <= '0;
                        core_start <= 1'b0;
                        m_valid_q  <= 1'b1;
                        state      <= DRAIN;
                    end
`ifdef ACORN128_HOST_TIMEOUT_EN
                    else if (run_cnt == 13'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q  <= 1'b1;
                        core_start <= 1'b0;
                        core_rst   <= 1'b1;
                        state      <= CLR;
                    end else begin
                        run_cnt <= run_cnt + 13'd1;
                    end
`endif
                end
                DRAIN: begin
                    if (bus.m_ready) begin
                        if (out_cnt == 3'(WORDS_OUT - 1)) begin
                            m_valid_q <= 1'b0;
                            core_rst  <= 1'b1;
                            state     <= CLR;
                        end else begin
                            out_cnt <= out_cnt + 3'd1;
                        end
                    end
                end
                CLR: begin
                    core_rst  <= 1'b0;
                    s_ready_q <= 1'b1;
                    state     <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Output words come straight from the captured buffer, so m_data and
    // m_last only move when out_cnt advances on an accepted transfer.
    assign bus.m_data  = out_buf[{out_cnt, 5'b0} +: WORD_W];
    assign bus.m_last  = m_valid_q && (out_cnt == 3'(WORDS_OUT - 1));
    assign bus.m_valid = m_valid_q;
    assign bus.s_ready = s_ready_q;

    assign core_encrypt = core_start;
    assign core_len     = 64'(DATA_LEN);
    assign core_key     = field_q[0];
    assign core_iv      = field_q[1];
    assign core_ad      = field_q[2];
    assign core_pt      = field_q[3];
    assign busy         = (state == RUN) || (state == DRAIN);

`ifdef ACORN128_HOST_TIMEOUT_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/acorn128_host_if.md
ACORN128_HOST_IF -- requirements
Module: acorn128_host_if

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8191: maximum RUN-state cycles before abort (used only with the timeout macro).
REQ-002 Ports, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  host input word valid.
- s_ready  out  1  block accepts a host word.
- s_data  in  32  host input word.
- m_valid  out  1  output word valid.
- m_ready  in  1  host accepts an output word.
- m_data  out  32  output word.
- m_last  out  1  marks the final output word.
- core_rst  out  1  one-cycle reset pulse to the cipher core.
- core_start  out  1  core start level.
- core_encrypt  out  1  core encrypt select.
- core_key  out  128  key to core.
- core_iv  out  128  IV to core.
- core_ad  out  128  associated data to core.
- core_pt  out  128  plaintext to core.
- core_len  out  64  data length to core.
- core_ready  in  1  core done.
- core_ct  in  128  core ciphertext.
- core_tag  in  128  core tag.
- busy  out  1  high in RUN or DRAIN.
- timeout_err  out  1  sticky abort flag.

Function
REQ-003 States SHALL be LOAD, RUN, DRAIN, CLR; reset state is LOAD.
REQ-004 LOAD: s_ready=1; a beat transfers when s_valid&&s_ready; 4-bit word_cnt increments per beat.
REQ-005 Beat order SHALL be key, IV, AD, PT, 4 words each; word k of a field loads bits [32k+31:32k].
REQ-006 On beat 16 (word_cnt 15), word_cnt SHALL wrap to 0, state -> RUN and core_start=1 from the next cycle.
REQ-007 core_encrypt SHALL equal core_start; core_len SHALL be constant 128.
REQ-008 core_key/iv/ad/pt SHALL hold stable from entering RUN until leaving DRAIN.
REQ-009 RUN: s_ready=0; when core_ready=1, capture core_ct and core_tag into a 256-bit output buffer, drop core_start, go DRAIN next cycle.
REQ-010 DRAIN: m_valid=1; emit ct words 0..3 then tag words 0..3, low word first; advance only on m_valid&&m_ready.
REQ-011 m_data/m_last SHALL hold stable while m_valid&&!m_ready; m_last=1 only on word 8.
REQ-012 After word 8 transfers, go CLR: core_rst=1 for exactly one cycle, then LOAD.
REQ-013 s_valid in RUN, DRAIN or CLR SHALL be ignored (no beat consumed).
REQ-014 busy=1 iff state is RUN or DRAIN.
REQ-015 First-beat-to-core_start latency SHALL be 16 accepted beats plus 1 cycle.

Reset
REQ-016 rst SHALL asynchronously force state LOAD, word_cnt 0, all data registers 0, s_ready 1, m_valid 0, m_last 0, core_start 0, core_rst 0, timeout_err 0.
REQ-017 rst mid-RUN or mid-DRAIN SHALL discard partial output; no m_valid until a new 16-beat load completes.

Configuration
REQ-018 Macro ACORN128_HOST_TIMEOUT_EN defined: a 13-bit RUN counter counts from 0; on reaching TIMEOUT_CYCLES without core_ready, set timeout_err, drop core_start, go CLR with no output emitted.
REQ-019 timeout_err SHALL clear on the next accepted beat in LOAD.
REQ-020 Macro undefined: no counter; RUN waits indefinitely; timeout_err tied to 0.

Structure
REQ-021 The shared acorn128 package SHALL hold the state enum, WORDS_IN=16, WORDS_OUT=8, and DATA_LEN=128.
REQ-022 A sub-module acorn128_word_pack SHALL implement the 32-to-128 shift-in for one field; it is instantiated four times.

Verification
REQ-023 Load key=0, IV=0, AD=0, PT=0, then core model asserts core_ready 4480 cycles later with ct=tag=128'h0: 8 zero words out, m_last on word 8, one core_rst pulse.
REQ-024 s_data=32'h0000_0001..32'h0000_0010: core_key=128'h00000004_00000003_00000002_00000001 and core_pt=128'h00000010_0000000F_0000000E_0000000D.
REQ-025 m_ready toggles 1,0,0,1 during DRAIN: no word repeated or skipped; m_data stable while stalled.
REQ-026 With macro defined, TIMEOUT_CYCLES=100 and core_ready held 0: timeout_err=1 at cycle 100 of RUN, core_rst pulses, m_valid never rises.
REQ-027 rst asserted at output word 3 then released: m_valid=0 and s_ready=1; a full new 16-beat load is required before any output.
REQ-028 s_valid held high during RUN: no beats consumed, and word_cnt=0 on return to LOAD.
